// File: rtl/sqrt_share_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_share_ctrl
//
// Shares one iterative 32/16-bit non-restoring square-root core between two
// requesters. A round-robin arbiter picks a requester in IDLE, the sequencer
// issues the core's one-cycle load, waits out the iteration, captures the root
// and remainder on the core's completion pulse and presents them to the owning
// requester until accepted. Each requester may cancel its own in-flight
// operation; the core itself cannot be aborted, so a cancelled operation is
// simply allowed to finish and its result is discarded.
//
// Ports
//   clock, resetn        system clock / asynchronous active-low reset (shared
//                        with the sqrt core)
//   req_valid/req_ready  per-requester request handshake (bit0 = requester 0);
//                        req_ready is one-hot or zero
//   req_d0/req_d1        radicands
//   req_tag0/req_tag1    opaque tags, returned unchanged with the result
//   cancel               per-requester abort of its own operation
//   rsp_valid/rsp_ready  per-requester response handshake; rsp_valid one-hot
//                        or zero
//   rsp_q/rsp_r/rsp_tag  shared result bus: root, remainder, tag
//   core_d, core_load    radicand and one-cycle start pulse to the core
//   core_busy            core iterating
//   core_ready           core one-cycle completion pulse
//   core_q, core_r       core root and adjusted remainder
//   ctrl_busy            high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module sqrt_share_ctrl #(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             resetn,

    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_d0,
    input  logic [31:0]      req_d1,
    input  logic [TAG_W-1:0] req_tag0,
    input  logic [TAG_W-1:0] req_tag1,
    input  logic [1:0]       cancel,

    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [15:0]      rsp_q,
    output logic [16:0]      rsp_r,
    output logic [TAG_W-1:0] rsp_tag,

    output logic [31:0]      core_d,
    output logic             core_load,
    input  logic             core_busy,
    input  logic             core_ready,
    input  logic [15:0]      core_q,
    input  logic [16:0]      core_r,

    output logic             ctrl_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t           state_reg;
    logic             last_grant_reg;   // requester served most recently
    logic             owner_reg;        // requester owning the current operation
    logic             drop_reg;         // current operation was cancelled
    logic [31:0]      core_d_reg;
    logic [15:0]      rsp_q_reg;
    logic [16:0]      rsp_r_reg;
    logic [TAG_W-1:0] tag_reg;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic any_req;
    logic win;          // index of the requester that would be granted
    logic accept;       // a grant is offered this cycle
    logic cancel_own;   // cancel from the current owner
    logic rsp_ack;      // rsp_ready from the current owner

    always_comb begin
        any_req = |req_valid;
        // With both requesting, the one not served last time wins; otherwise
        // the single valid requester wins (req_valid[1] selects it).
        if (req_valid == 2'b11) begin
            win = ~last_grant_reg;
        end else begin
            win = req_valid[1];
        end
    end

    // resetn gates the offer so req_ready reads zero while reset is held even
    // though the state register already shows IDLE. The core_busy term is an
    // interlock: a load is never issued onto a core that is still iterating.
    assign accept     = (state_reg == IDLE) && resetn && any_req && !core_busy;
    assign cancel_own = cancel[owner_reg];
    assign rsp_ack    = rsp_ready[owner_reg];

    // Per-requester one-hot handshake outputs, decoded from registered state.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic SEL = (gi == 1);
            assign req_ready[gi] = accept && (win == SEL);
            assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == SEL);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;     // requester 0 wins the first contest
            owner_reg      <= 1'b0;
            drop_reg       <= 1'b0;
            core_d_reg     <= '0;
            rsp_q_reg      <= '0;
            rsp_r_reg      <= '0;
            tag_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        core_d_reg     <= win ? req_d1   : req_d0;
                        tag_reg        <= win ? req_tag1 : req_tag0;
                        owner_reg      <= win;
                        last_grant_reg <= win;
                        drop_reg       <= 1'b0;
                        state_reg      <= LOAD;
                    end
                end

                LOAD: begin
                    if (cancel_own) begin
                        drop_reg <= 1'b1;
                    end
                    state_reg <= WAIT;
                end

                WAIT: begin
                    if (core_ready) begin
                        // A cancel arriving together with completion still
                        // discards the result.
                        if (drop_reg || cancel_own) begin
                            state_reg <= IDLE;
                        end else begin
                            rsp_q_reg <= core_q;
                            rsp_r_reg <= core_r;
                            state_reg <= RESP;
                        end
                    end else if (cancel_own) begin
                        drop_reg <= 1'b1;
                    end
                end

                RESP: begin
                    // Accept and cancel both retire the response; when they
                    // coincide the result counts as delivered.
                    if (rsp_ack || cancel_own) begin
                        state_reg <= IDLE;
                    end
                end

                DRAIN: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all taken straight from registers)
    // -------------------------------------------------------------------------
    assign core_load = (state_reg == LOAD);
    assign core_d    = core_d_reg;
    assign rsp_q     = rsp_q_reg;
    assign rsp_r     = rsp_r_reg;
    assign rsp_tag   = tag_reg;
    assign ctrl_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqrt_share_ctrl
//
// Bench for sqrt_share_ctrl. A behavioural sqrt core (load -> 16 busy cycles ->
// one-cycle ready pulse) is attached to the core port. Expected roots,
// remainders and latencies are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sqrt_share_ctrl;

    localparam int TAG_W = 4;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [31:0]      req_d0;
    logic [31:0]      req_d1;
    logic [TAG_W-1:0] req_tag0;
    logic [TAG_W-1:0] req_tag1;
    logic [1:0]       cancel;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [15:0]      rsp_q;
    logic [16:0]      rsp_r;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      core_d;
    logic             core_load;
    logic             core_busy;
    logic             core_ready;
    logic [15:0]      core_q;
    logic [16:0]      core_r;
    logic             ctrl_busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    sqrt_share_ctrl #(.TAG_W(TAG_W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_d0     (req_d0),
        .req_d1     (req_d1),
        .req_tag0   (req_tag0),
        .req_tag1   (req_tag1),
        .cancel     (cancel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_q      (rsp_q),
        .rsp_r      (rsp_r),
        .rsp_tag    (rsp_tag),
        .core_d     (core_d),
        .core_load  (core_load),
        .core_busy  (core_busy),
        .core_ready (core_ready),
        .core_q     (core_q),
        .core_r     (core_r),
        .ctrl_busy  (ctrl_busy)
    );

    // ---------------- behavioural sqrt core ----------------
    function automatic logic [15:0] isqrt(input logic [31:0] d);
        logic [15:0] q;
        logic [15:0] t;
        logic [31:0] tt;
        q = '0;
        for (int b = 15; b >= 0; b--) begin
            t  = q | (16'd1 << b);
            tt = 32'(t) * 32'(t);
            if (tt <= d) q = t;
        end
        return q;
    endfunction

    logic [4:0] cm_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            core_busy  <= 1'b0;
            core_ready <= 1'b0;
            cm_cnt     <= '0;
            core_q     <= '0;
            core_r     <= '0;
        end else begin
            core_ready <= 1'b0;
            if (core_load) begin
                core_busy <= 1'b1;
                cm_cnt    <= 5'd16;
                core_q    <= isqrt(core_d);
                core_r    <= 17'(core_d - 32'(isqrt(core_d)) * 32'(isqrt(core_d)));
            end else if (core_busy) begin
                if (cm_cnt == 5'd1) begin
                    core_busy  <= 1'b0;
                    core_ready <= 1'b1;
                end
                cm_cnt <= cm_cnt - 5'd1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // A load must never land on a busy core.
    always @(negedge clock) begin
        if (resetn && core_load) chk("load_while_busy", core_busy, 1'b0);
    end

    // One complete transaction whose request inputs are already driven.
    // Handshake cycle T is the current cycle; checks load at T+1, first
    // rsp_valid at T+19, the returned values, and the drop after accept.
    task automatic run_one(input string name, input logic [1:0] eg, input logic [31:0] ed,
                           input logic [15:0] eq, input logic [16:0] er,
                           input logic [3:0] et, input bit clear_valid);
        int n;
        #1;
        chk({name, ".req_ready"}, req_ready, eg);
        tick();
        if (clear_valid) req_valid = 2'b00;
        chk({name, ".core_load"}, core_load, 1'b1);
        chk({name, ".core_d"}, core_d, ed);
        chk({name, ".busy"}, ctrl_busy, 1'b1);
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chk({name, ".latency"}, n, 18);
        chk({name, ".rsp_valid"}, rsp_valid, eg);
        chk({name, ".rsp_q"}, rsp_q, eq);
        chk({name, ".rsp_r"}, rsp_r, er);
        chk({name, ".rsp_tag"}, rsp_tag, et);
        $display("txn %s: grant=%b d=0x%08h q=0x%04h r=0x%05h tag=%0d", name, eg, ed, rsp_q, rsp_r, rsp_tag);
        rsp_ready = eg;
        tick();
        rsp_ready = 2'b00;
        chk({name, ".rsp_drop"}, rsp_valid, 2'b00);
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chk({name, ".rsp_seen"}, (rsp_valid != 2'b00), 1'b1);
    endtask

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] d;
        logic [3:0]  tag;
        logic [15:0] q;
        logic [16:0] r;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{2'b01, 32'h0000_0011, 4'd3,  16'h0004, 17'h00001};
        vecs[1] = '{2'b10, 32'hFFFF_FFFF, 4'hA,  16'hFFFF, 17'h1FFFE};
        vecs[2] = '{2'b01, 32'h0000_0000, 4'h6,  16'h0000, 17'h00000};
        vecs[3] = '{2'b10, 32'd1000000,   4'hC,  16'd1000, 17'd0};

        req_valid = 2'b00; req_d0 = '0; req_d1 = '0;
        req_tag0 = '0; req_tag1 = '0; cancel = 2'b00; rsp_ready = 2'b00;

        // ---- reset state, with requests pending ----
        #2;
        req_valid = 2'b11;
        #1;
        chk("rst.req_ready", req_ready, 2'b00);
        chk("rst.flags", {rsp_valid, core_load, ctrl_busy}, 4'b0000);
        chk("rst.core_d", core_d, 32'd0);
        chk("rst.rsp_bus", {rsp_q, rsp_r, rsp_tag}, 37'd0);
        req_valid = 2'b00;
        tick(); tick();
        resetn = 1'b1;
        tick();

        // ---- table-driven single requests ----
        for (int i = 0; i < 4; i++) begin
            req_d0 = vecs[i].d; req_d1 = vecs[i].d;
            req_tag0 = vecs[i].tag; req_tag1 = vecs[i].tag;
            req_valid = vecs[i].grant;
            run_one($sformatf("vec%0d", i), vecs[i].grant, vecs[i].d,
                    vecs[i].q, vecs[i].r, vecs[i].tag, 1'b1);
        end

        // ---- contention from reset: grants alternate 0,1,0,1 ----
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        req_d0 = 32'd16; req_tag0 = 4'd1;
        req_d1 = 32'd2;  req_tag1 = 4'd2;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                run_one($sformatf("arb%0d", k), 2'b01, 32'd16, 16'd4, 17'd0, 4'd1, 1'b0);
            else
                run_one($sformatf("arb%0d", k), 2'b10, 32'd2, 16'd1, 17'd1, 4'd2, 1'b0);
        end
        req_valid = 2'b00;
        tick();

        // ---- backpressure: result held 10 cycles, nothing else issued ----
        req_d0 = 32'd49; req_tag0 = 4'd9;
        req_valid = 2'b01;
        #1;
        chk("bp.req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        wait_rsp("bp");
        req_d1 = 32'd2; req_tag1 = 4'd2;
        req_valid = 2'b10;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("bp.hold%0d", c),
                {rsp_valid, rsp_q, rsp_r, rsp_tag, core_load, req_ready},
                {2'b01, 16'd7, 17'd0, 4'd9, 1'b0, 2'b00});
            tick();
        end
        $display("txn bp: held q=0x%04h r=0x%05h tag=%0d", rsp_q, rsp_r, rsp_tag);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("bp.rsp_drop", rsp_valid, 2'b00);
        run_one("bp.next", 2'b10, 32'd2, 16'd1, 17'd1, 4'd2, 1'b1);

        // ---- cancel in WAIT at T+5: no result, idle at T+19 ----
        req_d0 = 32'h11; req_tag0 = 4'd3;
        req_valid = 2'b01;
        #1;
        chk("cw.req_ready", req_ready, 2'b01);
        tick();                                 // T+1
        req_valid = 2'b00;
        chk("cw.core_load", core_load, 1'b1);
        repeat (4) tick();                      // T+5
        cancel = 2'b01;
        tick();                                 // T+6
        cancel = 2'b00;
        req_d1 = 32'd1000000; req_tag1 = 4'd5;
        req_valid = 2'b10;
        n = 6;
        while (ctrl_busy && n < 40) begin
            #1;
            chk($sformatf("cw.quiet%0d", n), {rsp_valid, req_ready}, 4'b0000);
            tick();
            n++;
        end
        chk("cw.idle_cycle", n, 19);
        $display("txn cw: cancelled, idle at T+%0d", n);
        run_one("cw.next", 2'b10, 32'd1000000, 16'd1000, 17'd0, 4'd5, 1'b1);

        // ---- cancel in RESP; non-owner cancel/ready ignored ----
        req_d0 = 32'd100; req_tag0 = 4'd7;
        req_valid = 2'b01;
        #1;
        chk("cr.req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        wait_rsp("cr");
        chk("cr.rsp_q", rsp_q, 16'd10);
        cancel = 2'b10; rsp_ready = 2'b10;
        tick();
        cancel = 2'b00; rsp_ready = 2'b00;
        chk("cr.nonowner", rsp_valid, 2'b01);
        cancel = 2'b01;
        tick();
        cancel = 2'b00;
        chk("cr.dropped", {rsp_valid, ctrl_busy}, 3'b000);
        $display("txn cr: response cancelled");

        // ---- reset during WAIT at T+8 ----
        req_d1 = 32'h11; req_tag1 = 4'd3;
        req_valid = 2'b10;
        #1;
        chk("rw.req_ready", req_ready, 2'b10);
        tick();                                 // T+1
        req_valid = 2'b00;
        repeat (7) tick();                      // T+8
        chk("rw.busy_before", ctrl_busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rw.flags", {req_ready, rsp_valid, core_load, ctrl_busy}, 6'd0);
        chk("rw.core_d", core_d, 32'd0);
        chk("rw.rsp_bus", {rsp_q, rsp_r, rsp_tag}, 37'd0);
        tick();
        resetn = 1'b1;
        tick();
        $display("txn rw: reset in WAIT");
        req_d0 = 32'h11; req_tag0 = 4'd3;
        req_valid = 2'b01;
        run_one("rw.after", 2'b01, 32'h11, 16'h0004, 17'h00001, 4'd3, 1'b1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
